// File: rtl/fifo_push_ctrl_if.sv
// fifo_push_ctrl_if: board-side inputs and FIFO write-port outputs of the
// switch-driven FIFO producer.
//   master : the producer (fifo_push_ctrl) - consumes buttons/switches/Full,
//            drives push/Data_In and the status counters.
//   slave  : the surrounding board I/O and FIFO write port.
interface fifo_push_ctrl_if;

    // Raw board inputs (asynchronous, bouncy)
    logic       btn_push;
    logic       btn_burst;
    logic [3:0] sw;

    // FIFO write port (WR_CLK domain)
    logic       Full;
    logic       push;
    logic [3:0] Data_In;

    // Status
    logic       busy;
    logic [7:0] push_count;
    logic [3:0] drop_count;

    modport master (
        input  btn_push,
        input  btn_burst,
        input  sw,
        input  Full,
        output push,
        output Data_In,
        output busy,
        output push_count,
        output drop_count
    );

    modport slave (
        output btn_push,
        output btn_burst,
        output sw,
        output Full,
        input  push,
        input  Data_In,
        input  busy,
        input  push_count,
        input  drop_count
    );

endinterface

// File: rtl/fifo_push_ctrl.sv
// fifo_push_ctrl: write-side producer for the switch-driven dual-clock FIFO.
// Synchronises and debounces the push button (and optionally the burst
// button), samples the data switches, and drives push/Data_In in the WR_CLK
// domain without ever pushing into a full FIFO. A request that finds the
// FIFO full is held indefinitely; requests arriving while busy are dropped
// and counted.
//
// Optional feature: define FIFO_PUSH_BURST_EN to compile in the burst button
// path and the BURST state, which writes BURST_LEN incrementing words
// starting from the switch value. Without it btn_burst and BURST_LEN are
// ignored.
module fifo_push_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,  // >= 2
    parameter int unsigned BURST_LEN       = 8    // 1..16
) (
    input  logic             WR_CLK,
    input  logic             rst,
    fifo_push_ctrl_if.master bus
);

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1: the edge
    // that would take it to DEBOUNCE_CYCLES commits the new level instead.
    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1
`ifdef FIFO_PUSH_BURST_EN
        ,BURST = 2'd2
`endif
    } state_t;

    // Synchronisers
    logic            push_sync1;
    logic            push_sync2;
    logic [3:0]      sw_sync1;
    logic [3:0]      sw_sync2;

    // Push-button debounce and edge detect
    logic            push_stable;
    logic            push_stable_q;
    logic [DB_W-1:0] push_db_cnt;
    logic            req_push;

    logic            req_burst;

    // FSM and datapath
    state_t          state;
    logic [3:0]      data_q;
    logic            push_int;
    logic [1:0]      drop_inc;
    logic [4:0]      drop_sum;
    logic [7:0]      push_count_q;
    logic [3:0]      drop_count_q;

    // Two-flop synchronisers for the push button and the data switches
    always_ff @(posedge WR_CLK or posedge rst) begin
        if (rst) begin
            push_sync1 <= 1'b0;
            push_sync2 <= 1'b0;
            sw_sync1   <= 4'd0;
            sw_sync2   <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbour; blocking here
            // would collapse the two synchroniser stages into one.
            push_sync1 <= bus.btn_push;
            push_sync2 <= push_sync1;
            sw_sync1   <= bus.sw;
            sw_sync2   <= sw_sync1;
        end
    end

    // Push-button debounce: commit a new level after DEBOUNCE_CYCLES
    // consecutive differing samples, and keep a delayed copy for edge detect
    always_ff @(posedge WR_CLK or posedge rst) begin
        if (rst) begin
            push_stable   <= 1'b0;
            push_stable_q <= 1'b0;
            push_db_cnt   <= '0;
        end else begin
            push_stable_q <= push_stable;
            if (push_sync2 == push_stable) begin
                push_db_cnt <= '0;
            end else if (push_db_cnt == DB_LAST) begin
                push_stable <= push_sync2;
                push_db_cnt <= '0;
            end else begin
                push_db_cnt <= push_db_cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; a release makes no request
    assign req_push = push_stable & ~push_stable_q;

`ifdef FIFO_PUSH_BURST_EN
    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN - 1);

    logic            burst_sync1;
    logic            burst_sync2;
    logic            burst_stable;
    logic            burst_stable_q;
    logic [DB_W-1:0] burst_db_cnt;
    logic [3:0]      burst_cnt;

    // Two-flop synchroniser for the burst button
    always_ff @(posedge WR_CLK or posedge rst) begin
        if (rst) begin
            burst_sync1 <= 1'b0;
            burst_sync2 <= 1'b0;
        end else begin
            burst_sync1 <= bus.btn_burst;
            burst_sync2 <= burst_sync1;
        end
    end

    // Burst-button debounce, identical in behaviour to the push button
    always_ff @(posedge WR_CLK or posedge rst) begin
        if (rst) begin
            burst_stable   <= 1'b0;
            burst_stable_q <= 1'b0;
            burst_db_cnt   <= '0;
        end else begin
            burst_stable_q <= burst_stable;
            if (burst_sync2 == burst_stable) begin
                burst_db_cnt <= '0;
            end else if (burst_db_cnt == DB_LAST) begin
                burst_stable <= burst_sync2;
                burst_db_cnt <= '0;
            end else begin
                burst_db_cnt <= burst_db_cnt + 1'b1;
            end
        end
    end

    assign req_burst = burst_stable & ~burst_stable_q;
`else
    // Burst path compiled out: the button and the length are don't-cares
    logic unused_burst;
    assign unused_burst = ^{bus.btn_burst, 5'(BURST_LEN)};
    assign req_burst    = 1'b0;
`endif

    // Write strobe follows Full combinationally so a full FIFO is never pushed
    always_comb begin
        // NOTE: default first so every path assigns push_int and no latch
        // is inferred for the states that do not drive it.
        push_int = 1'b0;
        case (state)
            PEND:    push_int = ~bus.Full;
`ifdef FIFO_PUSH_BURST_EN
            BURST:   push_int = ~bus.Full;
`endif
            default: push_int = 1'b0;
        endcase
    end

    // Control FSM: latch switch data on a request, hold it while Full,
    // and step through the incrementing burst sequence
    always_ff @(posedge WR_CLK or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= 4'd0;
`ifdef FIFO_PUSH_BURST_EN
            burst_cnt <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_push) begin
                        data_q <= sw_sync2;
                        state  <= PEND;
                    end
`ifdef FIFO_PUSH_BURST_EN
                    else if (req_burst) begin
                        data_q    <= sw_sync2;
                        burst_cnt <= 4'd0;
                        state     <= BURST;
                    end
`endif
                end
                PEND: begin
                    if (push_int) begin
                        state <= IDLE;
                    end
                end
`ifdef FIFO_PUSH_BURST_EN
                BURST: begin
                    if (push_int) begin
                        data_q    <= data_q + 4'd1;
                        burst_cnt <= burst_cnt + 4'd1;
                        if (burst_cnt == BURST_LAST) begin
                            state <= IDLE;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Number of requests lost this cycle: both while busy, or the burst
    // request that loses a simultaneous tie in IDLE
    always_comb begin
        drop_inc = 2'd0;
        if (state == IDLE) begin
            drop_inc = {1'b0, req_push & req_burst};
        end else begin
            drop_inc = {1'b0, req_push} + {1'b0, req_burst};
        end
    end

    assign drop_sum = {1'b0, drop_count_q} + {3'b000, drop_inc};

    // Accepted-write counter (wrapping) and drop counter (saturating at 15)
    always_ff @(posedge WR_CLK or posedge rst) begin
        if (rst) begin
            push_count_q <= 8'd0;
            drop_count_q <= 4'd0;
        end else begin
            if (push_int) begin
                push_count_q <= push_count_q + 8'd1;
            end
            drop_count_q <= drop_sum[4] ? 4'hF : drop_sum[3:0];
        end
    end

    assign bus.push       = push_int;
    assign bus.Data_In    = data_q;
    assign bus.busy       = (state != IDLE);
    assign bus.push_count = push_count_q;
    assign bus.drop_count = drop_count_q;

endmodule
